// File: rtl/phase_seq_pkg.sv
// Shared types and constants for the phase sequencer.
//   state_e    : sequencer FSM states
//   PHASE_W    : width of the phase index
//   NUM_PHASES : number of phases per cycle
//   DEF_DUR_*  : default per-phase timer durations
//   dur_sel()  : picks the duration belonging to a phase index
package phase_seq_pkg;

    localparam int unsigned PHASE_W    = 2;
    localparam int unsigned NUM_PHASES = 4;

    localparam logic [7:0] DEF_DUR_0 = 8'h0A;
    localparam logic [7:0] DEF_DUR_1 = 8'h03;
    localparam logic [7:0] DEF_DUR_2 = 8'h0A;
    localparam logic [7:0] DEF_DUR_3 = 8'h03;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        ADVANCE
    } state_e;

    function automatic logic [7:0] dur_sel(input logic [PHASE_W-1:0] phase,
                                           input logic [7:0] d0,
                                           input logic [7:0] d1,
                                           input logic [7:0] d2,
                                           input logic [7:0] d3);
        logic [7:0] r;
        unique case (phase)
            2'd0:    r = d0;
            2'd1:    r = d1;
            2'd2:    r = d2;
            default: r = d3;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/phase_sequencer_tick_prescaler.sv
// Prescaler producing a registered one-cycle enable every PRESCALE enabled cycles.
//   clk    : clock
//   rst_i  : asynchronous active-high reset
//   clr_i  : return the count to 0 (has priority over en_i)
//   en_i   : the coming cycle is a counting cycle
//   tick_o : registered tick, high in the counting cycle whose count is PRESCALE-1
// PRESCALE of 0 behaves as 1 (tick on every counting cycle).
module tick_prescaler #(
    parameter logic [15:0] PRESCALE = 16'd1000
) (
    input  logic clk,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [15:0] LAST = (PRESCALE == 16'd0) ? 16'd0 : PRESCALE - 16'd1;

    logic [15:0] cnt_q, cnt_d;
    logic        tick_q, tick_d;

    // Inputs describe the next cycle, so the tick is computed one edge ahead and
    // lands in the same cycle as the count value it belongs to.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr_i) begin
            cnt_d = 16'd0;
        end else if (en_i) begin
            if (cnt_q == LAST) begin
                tick_d = 1'b1;
                cnt_d  = 16'd0;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= 16'd0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/phase_sequencer.sv
// Four-phase sequencer driving a downstream timer: loads a per-phase duration,
// enables the timer with prescaled ticks, and advances when the timer expires.
//   clk            : clock
//   rst_i          : asynchronous active-high reset
//   start_i        : start from IDLE (level)
//   stop_i         : abort to IDLE (level, highest priority)
//   count_ended_i  : timer expired pulse, honoured only in RUN
//   load_en_o      : strobe loading load_address_o into the timer
//   load_address_o : duration for the current phase, held outside LOAD
//   tick_en_o      : prescaled timer enable, only in RUN
//   phase_o        : current phase index
//   busy_o         : high outside IDLE
//   cycle_done_o   : pulse in the ADVANCE cycle that wraps phase 3 -> 0
// All outputs are registered and coincide with the state they describe.
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter logic [15:0] PRESCALE = 16'd1000,
    parameter logic [7:0]  DUR_0    = DEF_DUR_0,
    parameter logic [7:0]  DUR_1    = DEF_DUR_1,
    parameter logic [7:0]  DUR_2    = DEF_DUR_2,
    parameter logic [7:0]  DUR_3    = DEF_DUR_3,
    parameter logic        REPEAT   = 1'b1
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               count_ended_i,
    output logic               load_en_o,
    output logic [7:0]         load_address_o,
    output logic               tick_en_o,
    output logic [PHASE_W-1:0] phase_o,
    output logic               busy_o,
    output logic               cycle_done_o
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               load_en_q, load_en_d;
    logic [7:0]         load_addr_q, load_addr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               run_next;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        done_d  = 1'b0;
        if (state_q != IDLE && stop_i) begin
            state_d = IDLE;
            phase_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i && !stop_i) begin
                        state_d = LOAD;
                        phase_d = '0;
                    end
                end
                LOAD: state_d = RUN;
                RUN: begin
                    // Phase moves on entry to ADVANCE so phase_o and cycle_done_o
                    // already show the new phase during the ADVANCE cycle.
                    if (count_ended_i) begin
                        state_d = ADVANCE;
                        phase_d = phase_q + 1'b1;
                        done_d  = (phase_q == LAST_PHASE);
                    end
                end
                ADVANCE: begin
                    // phase_q == 0 here means the cycle just wrapped.
                    if (phase_q == '0 && !REPEAT) state_d = IDLE;
                    else                          state_d = LOAD;
                end
                default: state_d = IDLE;
            endcase
        end

        run_next    = (state_d == RUN);
        load_en_d   = (state_d == LOAD);
        busy_d      = (state_d != IDLE);
        load_addr_d = load_en_d ? dur_sel(phase_d, DUR_0, DUR_1, DUR_2, DUR_3) : load_addr_q;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            load_en_q   <= 1'b0;
            load_addr_q <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            load_en_q   <= load_en_d;
            load_addr_q <= load_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Count clears whenever the next cycle is not RUN, so every RUN stint starts at 0.
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst_i  (rst_i),
        .clr_i  (!run_next),
        .en_i   (run_next),
        .tick_o (tick_en_o)
    );

    assign load_en_o      = load_en_q;
    assign load_address_o = load_addr_q;
    assign phase_o        = phase_q;
    assign busy_o         = busy_q;
    assign cycle_done_o   = done_q;

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

    typedef struct {
        logic       start;
        logic       stop;
        logic       ce;
        logic       ld;
        logic [7:0] addr;
        logic       tick;
        logic [1:0] ph;
        logic       busy;
        logic       done;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic ce = 1'b0;
    logic sel = 1'b0;

    logic       a_ld, a_tick, a_busy, a_done;
    logic [7:0] a_addr;
    logic [1:0] a_ph;
    logic       b_ld, b_tick, b_busy, b_done;
    logic [7:0] b_addr;
    logic [1:0] b_ph;

    logic       o_ld, o_tick, o_busy, o_done;
    logic [7:0] o_addr;
    logic [1:0] o_ph;

    int n_checks = 0;
    int n_fail = 0;

    vec_t tab_a[$];
    vec_t tab_b[$];

    always #5 clk = ~clk;

    phase_sequencer #(
        .PRESCALE (16'd4),
        .DUR_0    (8'h11),
        .DUR_1    (8'h22),
        .DUR_2    (8'h33),
        .DUR_3    (8'h44),
        .REPEAT   (1'b1)
    ) dut_a (
        .clk            (clk),
        .rst_i          (rst),
        .start_i        (start),
        .stop_i         (stop),
        .count_ended_i  (ce),
        .load_en_o      (a_ld),
        .load_address_o (a_addr),
        .tick_en_o      (a_tick),
        .phase_o        (a_ph),
        .busy_o         (a_busy),
        .cycle_done_o   (a_done)
    );

    phase_sequencer #(
        .PRESCALE (16'd1),
        .REPEAT   (1'b0)
    ) dut_b (
        .clk            (clk),
        .rst_i          (rst),
        .start_i        (start),
        .stop_i         (stop),
        .count_ended_i  (ce),
        .load_en_o      (b_ld),
        .load_address_o (b_addr),
        .tick_en_o      (b_tick),
        .phase_o        (b_ph),
        .busy_o         (b_busy),
        .cycle_done_o   (b_done)
    );

    always_comb begin
        o_ld   = sel ? b_ld   : a_ld;
        o_addr = sel ? b_addr : a_addr;
        o_tick = sel ? b_tick : a_tick;
        o_ph   = sel ? b_ph   : a_ph;
        o_busy = sel ? b_busy : a_busy;
        o_done = sel ? b_done : a_done;
    end

    function automatic vec_t mk(input logic s, input logic p, input logic c,
                                input logic ld, input logic [7:0] addr, input logic tick,
                                input logic [1:0] ph, input logic busy, input logic done);
        vec_t v;
        v.start = s; v.stop = p; v.ce = c;
        v.ld = ld; v.addr = addr; v.tick = tick; v.ph = ph; v.busy = busy; v.done = done;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input vec_t v);
        chk({tag, ".load_en"},    idx, {7'd0, o_ld},   {7'd0, v.ld});
        chk({tag, ".load_addr"},  idx, o_addr,         v.addr);
        chk({tag, ".tick_en"},    idx, {7'd0, o_tick}, {7'd0, v.tick});
        chk({tag, ".phase"},      idx, {6'd0, o_ph},   {6'd0, v.ph});
        chk({tag, ".busy"},       idx, {7'd0, o_busy}, {7'd0, v.busy});
        chk({tag, ".cycle_done"}, idx, {7'd0, o_done}, {7'd0, v.done});
    endtask

    // Apply inputs, let one rising edge sample them, then look 1 time unit later.
    task automatic step(input logic s, input logic p, input logic c);
        start = s;
        stop  = p;
        ce    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string tag, input vec_t tab[$]);
        for (int i = 0; i < tab.size(); i++) begin
            step(tab[i].start, tab[i].stop, tab[i].ce);
            chk_all(tag, i, tab[i]);
        end
    endtask

    initial begin
        // PRESCALE=4, REPEAT=1, durations 11/22/33/44
        tab_a.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        tab_a.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0, 0, 0)); // ce in IDLE ignored
        tab_a.push_back(mk(1, 0, 0, 1, 8'h11, 0, 0, 1, 0)); // LOAD phase 0
        tab_a.push_back(mk(1, 0, 0, 0, 8'h11, 0, 0, 1, 0)); // RUN 1, start held
        tab_a.push_back(mk(0, 0, 0, 0, 8'h11, 0, 0, 1, 0)); // RUN 2
        tab_a.push_back(mk(0, 0, 0, 0, 8'h11, 0, 0, 1, 0)); // RUN 3
        tab_a.push_back(mk(0, 0, 0, 0, 8'h11, 1, 0, 1, 0)); // RUN 4 tick
        tab_a.push_back(mk(0, 0, 0, 0, 8'h11, 0, 0, 1, 0)); // RUN 5
        tab_a.push_back(mk(0, 0, 1, 0, 8'h11, 0, 1, 1, 0)); // ADVANCE -> ph1
        tab_a.push_back(mk(0, 0, 1, 1, 8'h22, 0, 1, 1, 0)); // LOAD (ce ignored in ADVANCE)
        tab_a.push_back(mk(0, 0, 1, 0, 8'h22, 0, 1, 1, 0)); // RUN (ce ignored in LOAD)
        tab_a.push_back(mk(0, 0, 1, 0, 8'h22, 0, 2, 1, 0)); // ADVANCE -> ph2
        tab_a.push_back(mk(0, 0, 0, 1, 8'h33, 0, 2, 1, 0)); // LOAD DUR_2
        tab_a.push_back(mk(0, 0, 0, 0, 8'h33, 0, 2, 1, 0));
        tab_a.push_back(mk(0, 0, 1, 0, 8'h33, 0, 3, 1, 0)); // ADVANCE -> ph3
        tab_a.push_back(mk(0, 0, 0, 1, 8'h44, 0, 3, 1, 0));
        tab_a.push_back(mk(0, 0, 0, 0, 8'h44, 0, 3, 1, 0));
        tab_a.push_back(mk(0, 0, 1, 0, 8'h44, 0, 0, 1, 1)); // wrap, cycle_done
        tab_a.push_back(mk(0, 0, 0, 1, 8'h11, 0, 0, 1, 0)); // REPEAT: LOAD again
        tab_a.push_back(mk(0, 0, 0, 0, 8'h11, 0, 0, 1, 0));
        tab_a.push_back(mk(0, 0, 0, 0, 8'h11, 0, 0, 1, 0));
        tab_a.push_back(mk(0, 1, 1, 0, 8'h11, 0, 0, 0, 0)); // stop beats ce
        tab_a.push_back(mk(1, 1, 0, 0, 8'h11, 0, 0, 0, 0)); // stop beats start
        tab_a.push_back(mk(1, 0, 0, 1, 8'h11, 0, 0, 1, 0));
        tab_a.push_back(mk(0, 1, 0, 0, 8'h11, 0, 0, 0, 0)); // stop in LOAD

        // PRESCALE=1, REPEAT=0, default durations 0A/03/0A/03
        tab_b.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0, 0, 0));
        tab_b.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0, 0, 0));
        tab_b.push_back(mk(1, 0, 0, 1, 8'h0A, 0, 0, 1, 0));
        tab_b.push_back(mk(0, 0, 0, 0, 8'h0A, 1, 0, 1, 0)); // tick every RUN cycle
        tab_b.push_back(mk(0, 0, 0, 0, 8'h0A, 1, 0, 1, 0));
        tab_b.push_back(mk(0, 0, 0, 0, 8'h0A, 1, 0, 1, 0));
        tab_b.push_back(mk(0, 0, 1, 0, 8'h0A, 0, 1, 1, 0));
        tab_b.push_back(mk(0, 0, 0, 1, 8'h03, 0, 1, 1, 0));
        tab_b.push_back(mk(0, 0, 1, 0, 8'h03, 1, 1, 1, 0));
        tab_b.push_back(mk(0, 0, 1, 0, 8'h03, 0, 2, 1, 0));
        tab_b.push_back(mk(0, 0, 0, 1, 8'h0A, 0, 2, 1, 0));
        tab_b.push_back(mk(0, 0, 0, 0, 8'h0A, 1, 2, 1, 0));
        tab_b.push_back(mk(0, 0, 1, 0, 8'h0A, 0, 3, 1, 0));
        tab_b.push_back(mk(0, 0, 0, 1, 8'h03, 0, 3, 1, 0));
        tab_b.push_back(mk(0, 0, 0, 0, 8'h03, 1, 3, 1, 0));
        tab_b.push_back(mk(0, 0, 1, 0, 8'h03, 0, 0, 1, 1)); // wrap, cycle_done
        tab_b.push_back(mk(0, 0, 0, 0, 8'h03, 0, 0, 0, 0)); // stopped
        tab_b.push_back(mk(0, 0, 1, 0, 8'h03, 0, 0, 0, 0)); // no further load

        // Reset state of both instances
        repeat (2) @(posedge clk);
        #1;
        sel = 1'b0;
        chk_all("reset_a", 0, mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        sel = 1'b1;
        #1;
        chk_all("reset_b", 0, mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        sel = 1'b0;
        rst = 1'b0;

        run_table("tab_a", tab_a);

        // Asynchronous reset mid-RUN in phase 2, landing on a tick cycle
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 1); // ADVANCE ph1
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 1); // ADVANCE ph2
        step(0, 0, 0); // LOAD
        chk("pre_rst.load_addr", 0, o_addr, 8'h33);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        chk("pre_rst.tick_en", 0, {7'd0, o_tick}, 8'd1);
        chk("pre_rst.phase",   0, {6'd0, o_ph},   8'd2);
        #3;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1);
            chk_all("post_rst_idle", i, mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        end
        step(1, 0, 0);
        chk_all("post_rst_start", 0, mk(0, 0, 0, 1, 8'h11, 0, 0, 1, 0));

        // Second configuration
        step(0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sel = 1'b1;
        #1;
        run_table("tab_b", tab_b);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
